clk_tick_divider: RTL
=====================

// Module: clk_tick_divider
// PURPOSE
//  Synchronous, parametrised clock divider for slow timing (display refresh, blink, seconds).
//  N_CH independent down-counters, each with a runtime-programmable divisor.
//  Each channel drives a one-cycle tick strobe and a square wave (toggles on each tick).
//  Optional cascade mode: channel i counts the wraps of channel i-1 instead of clk cycles.
//  Everything runs in the single clk domain; no derived clocks are created.
// PARAMETERS
//  N_CH      3           number of divider channels (>=1)
//  CNT_W     26          counter/divisor width in bits
//  DIV_INIT  24_999_999  divisor loaded into every channel at reset
//  CASCADE   0           0 = every channel steps on clk; 1 = channel i>0 steps on wrap of i-1
//  CH_W      $clog2(N_CH) (min 1)  width of the config channel select
// PORTS
//  clk      in   1          system clock; all logic on posedge
//  rst      in   1          synchronous reset, active-high
//  en       in   1          global count enable
//  cfg_we   in   1          divisor write strobe
//  cfg_ch   in   CH_W       channel index to write
//  cfg_div  in   CNT_W      new divisor D; channel period = D+1 steps
//  tick     out  N_CH       registered one-cycle pulse per channel wrap
//  sq       out  N_CH       registered square wave, toggles on each wrap (period 2*(D+1) steps)
// BEHAVIOUR
//  - Per-channel state: div[i], cnt[i] (CNT_W bits); outputs tick[i] and sq[i] (registered).
//  - Reset (rst=1 at posedge): div[i]=cnt[i]=DIV_INIT, tick=0, sq=0. Overrides all other inputs.
//  - Step strobe (combinational):
//      step[0] = en
//      step[i] = en & (CASCADE ? wrap[i-1] : 1)
//      wrap[i] = step[i] & (cnt[i]==0)
//  - Per posedge, per channel, in priority order:
//      1. cfg_we & cfg_ch==i: div[i]<=cfg_div, cnt[i]<=cfg_div, tick[i]<=0, sq[i] holds
//         (restart; this also suppresses a wrap in the same cycle).
//      2. wrap[i]: cnt[i]<=div[i], tick[i]<=1, sq[i]<=~sq[i].
//      3. step[i] & cnt[i]!=0: cnt[i]<=cnt[i]-1, tick[i]<=0.
//      4. otherwise: cnt/sq hold, tick[i]<=0.
//  - Timing: tick[i] is high for exactly one clk cycle per wrap and is never held high.
//  - Latency: with en=1 continuously from reset release, the first tick[0] is high after
//    posedge DIV_INIT+1; tick[0] then repeats every DIV_INIT+1 cycles.
//  - D=0: the channel wraps on every step, so in non-cascade mode tick[i] stays high
//    continuously and sq[i] toggles every cycle.
//  - Cascade: channel i period = (div[i]+1) * period(i-1).
//    A config restart of channel i-1 does not reset channel i.
//  - en=0: all counters freeze, tick forced to 0, sq holds; config writes are still accepted.
//  - cfg_ch >= N_CH: the write is ignored and no state changes.
//  - Counter arithmetic is unsigned modulo 2^CNT_W. cnt never underflows because it reloads at 0.
//  - Reset mid-count: every channel returns to DIV_INIT immediately; programmed divisors are lost.
// TESTING
//  1. Reset: DIV_INIT=4, N_CH=3, en=1 -> tick[0] first high after posedge 5,
//     then every 5 cycles; sq[0] period 10.
//  2. Reprogram: write cfg_ch=1, cfg_div=2 mid-count -> tick[1] every 3 cycles,
//     first at 3 cycles after the write; channels 0 and 2 are unaffected.
//  3. D=0 and enable gating: cfg_div=0 -> tick stays high and sq toggles every cycle;
//     en=0 for 7 cycles -> tick=0, cnt/sq frozen, counting resumes exactly where it stopped.
//  4. Cascade (CASCADE=1, div={1,2,3}) -> tick[1] every 6 cycles, tick[2] every 24 cycles;
//     tick[2] coincides with tick[1] and tick[0].
//  5. Collision: cfg_we to ch0 in the cycle cnt[0]==0 -> no tick, sq[0] unchanged,
//     cnt[0]=cfg_div; write with cfg_ch=3 (N_CH=3) -> no state change.
//  6. rst asserted mid-count after reprogramming -> the next cycle shows all tick=0, sq=0,
//     and periods revert to DIV_INIT+1.

Source files
------------

// File: rtl/clk_tick_divider_if.sv
// Purpose: control and strobe bundle of the tick divider: count enable,
//          divisor write port (we/ch/div), and per-channel tick and square-wave outputs.
// Ports:   master drives en/cfg_*, reads tick/sq; slave is the divider itself.
interface clk_tick_divider_if #(
    parameter int N_CH  = 3,
    parameter int CNT_W = 26,
    parameter int CH_W  = (N_CH > 1) ? $clog2(N_CH) : 1
);
    logic             en;
    logic             cfg_we;
    logic [CH_W-1:0]  cfg_ch;
    logic [CNT_W-1:0] cfg_div;
    logic [N_CH-1:0]  tick;
    logic [N_CH-1:0]  sq;

    modport master (
        output en, cfg_we, cfg_ch, cfg_div,
        input  tick, sq
    );

    modport slave (
        input  en, cfg_we, cfg_ch, cfg_div,
        output tick, sq
    );
endinterface

// File: rtl/clk_tick_divider.sv
// Purpose: N_CH runtime-programmable down-counter dividers producing a one-cycle tick
//          per wrap and a square wave toggling on every wrap; optional cascade of channels.
// Latency: tick/sq are registered; a channel holding cnt==0 ticks on the next posedge.
// Ports:   clk, rst (sync, active-high); bus (slave) carries en, cfg_we/cfg_ch/cfg_div,
//          tick[N_CH], sq[N_CH]. No backpressure: config writes are accepted every cycle.
module clk_tick_divider #(
    parameter int          N_CH     = 3,
    parameter int          CNT_W    = 26,
    parameter int unsigned DIV_INIT = 24_999_999,
    parameter int          CASCADE  = 0
) (
    input  logic               clk,
    input  logic               rst,
    clk_tick_divider_if.slave  bus
);
    localparam int CH_W = (N_CH > 1) ? $clog2(N_CH) : 1;
    localparam logic [CNT_W-1:0] DIV_RST = CNT_W'(DIV_INIT);

    for (genvar g = 0; g < N_CH; g++) begin : g_ch
        logic [CNT_W-1:0] div_q, div_d;
        logic [CNT_W-1:0] cnt_q, cnt_d;
        logic             tick_q, tick_d;
        logic             sq_q, sq_d;
        logic             step_c;
        logic             wrap_c;
        logic             cfg_hit_c;

        // Channel 0 (and every channel in free-running mode) steps on each enabled clk;
        // in cascade mode a channel steps only when its predecessor wraps.
        if (g == 0 || CASCADE == 0) begin : g_free
            assign step_c = bus.en;
        end else begin : g_casc
            assign step_c = bus.en & g_ch[g-1].wrap_c;
        end

        assign wrap_c    = step_c & (cnt_q == '0);
        // Indices at or above N_CH never match, so such writes are dropped.
        assign cfg_hit_c = bus.cfg_we & (bus.cfg_ch == CH_W'(g));

        always_comb begin
            div_d  = div_q;
            cnt_d  = cnt_q;
            tick_d = 1'b0;
            sq_d   = sq_q;
            if (cfg_hit_c) begin
                // Restart wins over a coincident wrap: no tick, square wave holds.
                div_d = bus.cfg_div;
                cnt_d = bus.cfg_div;
            end else if (wrap_c) begin
                cnt_d  = div_q;
                tick_d = 1'b1;
                sq_d   = ~sq_q;
            end else if (step_c) begin
                cnt_d = cnt_q - 1'b1;
            end
        end

        always_ff @(posedge clk) begin
            if (rst) begin
                div_q  <= DIV_RST;
                cnt_q  <= DIV_RST;
                tick_q <= 1'b0;
                sq_q   <= 1'b0;
            end else begin
                div_q  <= div_d;
                cnt_q  <= cnt_d;
                tick_q <= tick_d;
                sq_q   <= sq_d;
            end
        end

        assign bus.tick[g] = tick_q;
        assign bus.sq[g]   = sq_q;
    end
endmodule
